// File: rtl/corefifo_rd_ctrl.sv
// Read-domain controller for the async COREFIFO: pointer decode, RAM read sequencing and status.
// Build option COREFIFO_FWFT_EN selects first-word-fall-through; default is standard read mode.
module corefifo_rd_ctrl #(
    parameter int ADDRWIDTH     = 3,
    parameter int DWIDTH        = 8,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 srstn,
    input  logic                 re,
    input  logic [ADDRWIDTH:0]   wptr_gray_sync,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic [ADDRWIDTH-1:0] ram_raddr,
    output logic                 ram_ren,
    input  logic [DWIDTH-1:0]    ram_rdata,
    output logic [DWIDTH-1:0]    dout,
    output logic                 dvld,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rdcnt,
    output logic                 underflow
);
    localparam int             PW    = ADDRWIDTH + 1;
    localparam logic [PW-1:0]  AE_TH = PW'(AEMPTY_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_gray_q, rptr_gray_d;
    logic          underflow_q, underflow_d;
    logic [PW-1:0] wbin;
    logic [PW-1:0] cnt_int;
    logic          empty_int;
    logic          fetch;

`ifdef COREFIFO_FWFT_EN
    // state  | meaning
    // EMPTY  | no head word presented on dout
    // VALID  | dout carries the head word fetched last cycle or earlier
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;
    logic [0:0] state_q, state_d;
`else
    logic dvld_q, dvld_d;
`endif

    always_comb begin
        wbin        = gray2bin(wptr_gray_sync);
        empty_int   = (wbin == rbin_q);
        cnt_int     = wbin - rbin_q;
        fetch       = 1'b0;
        empty       = empty_int;
        rdcnt       = cnt_int;
        underflow_d = 1'b0;
`ifdef COREFIFO_FWFT_EN
        state_d     = state_q;
        empty       = (state_q == ST_EMPTY);
        rdcnt       = cnt_int + PW'(state_q == ST_VALID);
        underflow_d = re & (state_q == ST_EMPTY);
        if (state_q == ST_EMPTY) begin
            if (!empty_int) begin
                fetch   = 1'b1;
                state_d = ST_VALID;
            end
        end else if (re) begin
            if (!empty_int) begin
                fetch = 1'b1;
            end else begin
                state_d = ST_EMPTY;
            end
        end
`else
        fetch       = re & !empty_int;
        underflow_d = re & empty_int;
`endif
        // Either reset blocks the RAM read so no fetch is left in flight.
        ram_ren     = fetch & arstn & srstn;
        rbin_d      = rbin_q + PW'(ram_ren);
        rptr_gray_d = rbin_q ^ (rbin_q >> 1);
`ifndef COREFIFO_FWFT_EN
        dvld_d      = ram_ren;
`endif
        if (!srstn) begin
            rbin_d      = '0;
            rptr_gray_d = '0;
            underflow_d = 1'b0;
`ifdef COREFIFO_FWFT_EN
            state_d     = ST_EMPTY;
`else
            dvld_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            underflow_q <= 1'b0;
`ifdef COREFIFO_FWFT_EN
            state_q     <= ST_EMPTY;
`else
            dvld_q      <= 1'b0;
`endif
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= rptr_gray_d;
            underflow_q <= underflow_d;
`ifdef COREFIFO_FWFT_EN
            state_q     <= state_d;
`else
            dvld_q      <= dvld_d;
`endif
        end
    end

    assign rptr_gray = rptr_gray_q;
    assign ram_raddr = rbin_q[ADDRWIDTH-1:0];
    assign dout      = ram_rdata;
    assign underflow = underflow_q;
    assign aempty    = (rdcnt <= AE_TH);
`ifdef COREFIFO_FWFT_EN
    assign dvld      = 1'b0;
`else
    assign dvld      = dvld_q;
`endif

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Scoreboard bench for corefifo_rd_ctrl (ADDRWIDTH=3, DWIDTH=8, AEMPTY_THRESH=1).
// Stimulus queues expected RAM reads, data words and underflow cycles; a monitor pops them.
module tb_corefifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       arstn, srstn, re;
    logic [3:0] wptr_gray_sync;
    logic [3:0] rptr_gray;
    logic [2:0] ram_raddr;
    logic       ram_ren;
    logic [7:0] ram_rdata = 8'h00;
    logic [7:0] dout;
    logic       dvld, empty, aempty, underflow;
    logic [3:0] rdcnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int q_raddr[$];
    int q_dout[$];
    int q_uf[$];

    localparam logic [3:0] G0 = 4'b0000, G1 = 4'b0001, G3 = 4'b0010;
    localparam logic [3:0] G8 = 4'b1100, G9 = 4'b1101;

    corefifo_rd_ctrl #(.ADDRWIDTH(3), .DWIDTH(8), .AEMPTY_THRESH(1)) dut (
        .clk(clk), .arstn(arstn), .srstn(srstn), .re(re),
        .wptr_gray_sync(wptr_gray_sync), .rptr_gray(rptr_gray),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
        .dout(dout), .dvld(dvld), .empty(empty), .aempty(aempty),
        .rdcnt(rdcnt), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Registered RAM: word at address a holds 8'hA0 + a.
    always @(posedge clk) if (ram_ren) ram_rdata <= 8'hA0 + 8'(ram_raddr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic rd(input int addr);
        q_raddr.push_back(addr);
`ifndef COREFIFO_FWFT_EN
        q_dout.push_back(8'hA0 + addr);
`endif
    endtask

    task automatic step(input logic i_re, input logic [3:0] i_wg, input logic e_empty,
                        input int e_cnt, input logic e_aempty, input logic e_uf);
        @(posedge clk);
        #1;
        srstn = 1'b1;
        re = i_re;
        wptr_gray_sync = i_wg;
        if (e_uf) q_uf.push_back(cyc + 1);
        @(negedge clk);
        chk("empty", 32'(empty), 32'(e_empty));
        chk("rdcnt", 32'(rdcnt), 32'(e_cnt));
        chk("aempty", 32'(aempty), 32'(e_aempty));
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (ram_ren) begin
                if (q_raddr.size() == 0) chk("ren_unexpected", 32'(ram_ren), 32'd0);
                else begin e = q_raddr.pop_front(); chk("raddr", 32'(ram_raddr), 32'(e)); end
            end
            if (dvld) begin
                if (q_dout.size() == 0) chk("dvld_unexpected", 32'(dvld), 32'd0);
                else begin e = q_dout.pop_front(); chk("dout", 32'(dout), 32'(e)); end
            end
            if (underflow) begin
                if (q_uf.size() == 0) chk("uf_unexpected", 32'(underflow), 32'd0);
                else begin e = q_uf.pop_front(); chk("uf_cycle", 32'(cyc), 32'(e)); end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        arstn = 1'b0; srstn = 1'b1; re = 1'b0; wptr_gray_sync = G0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(aempty), 32'd1);
        chk("rst_rdcnt", 32'(rdcnt), 32'd0);
        chk("rst_ren", 32'(ram_ren), 32'd0);
        chk("rst_rptr", 32'(rptr_gray), 32'd0);
        chk("rst_dvld", 32'(dvld), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
`ifndef COREFIFO_FWFT_EN
        // Three words, four pops: the fourth underflows.
        rd(0); step(1, G3, 0, 3, 0, 0);
        rd(1); step(1, G3, 0, 2, 0, 0);
        rd(2); step(1, G3, 0, 1, 1, 0);
        step(1, G3, 1, 0, 1, 1);
        step(0, G3, 1, 0, 1, 0);
        chk("rptr_after3", 32'(rptr_gray), 32'b0010);
        // Sync reset with five words pending and re asserted.
        step(0, G8, 0, 5, 0, 0);
        @(posedge clk);
        #1 srstn = 1'b0; re = 1'b1;
        @(negedge clk);
        chk("srst_ren", 32'(ram_ren), 32'd0);
        step(0, G0, 1, 0, 1, 0);
        chk("srst_rptr", 32'(rptr_gray), 32'd0);
        // Full FIFO, read all eight then one more across the address wrap.
        step(0, G8, 0, 8, 0, 0);
        for (int i = 0; i < 8; i++) begin
            rd(i);
            step(1, G8, 0, 8 - i, (8 - i) <= 1, 0);
        end
        step(0, G8, 1, 0, 1, 0);
        step(0, G8, 1, 0, 1, 0);
        chk("rptr_full", 32'(rptr_gray), 32'b1100);
        rd(0); step(1, G9, 0, 1, 1, 0);
        step(0, G9, 1, 0, 1, 0);
`else
        rd(0); step(0, G1, 1, 1, 1, 0);
        step(1, G1, 0, 1, 1, 0);
        chk("fwft_dout", 32'(dout), 32'hA0);
        step(0, G1, 1, 0, 1, 0);
        step(1, G1, 1, 0, 1, 1);
        step(0, G1, 1, 0, 1, 0);
`endif
        repeat (3) @(negedge clk);
        chk("q_raddr_drained", 32'(q_raddr.size()), 32'd0);
        chk("q_dout_drained", 32'(q_dout.size()), 32'd0);
        chk("q_uf_drained", 32'(q_uf.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
